// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one ALU between two requesters and holds one operation in flight.
// Responses are registered: a legal op answers two cycles after its grant, an illegal one after one; rsp_ready=0 holds the response and blocks new grants.
module alu_arbiter #(
  parameter int NUM_OPS = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req1_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_out,
  input  logic        alu_cf,
  input  logic        alu_of,
  input  logic        alu_zf,
  input  logic        alu_sf,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_out,
  output logic [3:0]  rsp_flags,
  output logic        rsp_err,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [4:0] NUM_OPS_W = 5'(NUM_OPS);

  logic [1:0]  state_q;
  logic        last_grant_q;
  logic        grant_vld;
  logic        grant_id;
  logic [31:0] gnt_a;
  logic [31:0] gnt_b;
  logic [3:0]  gnt_op;
  logic        gnt_legal;
  logic [3:0]  flag_en;

  // Grants only exist in IDLE out of reset; a tie goes to whoever was not granted last.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    if (rst_n && state_q == ST_IDLE) begin
      if (req0_valid && req1_valid) begin
        grant_vld = 1'b1;
        grant_id  = ~last_grant_q;
      end else if (req0_valid) begin
        grant_vld = 1'b1;
        grant_id  = 1'b0;
      end else if (req1_valid) begin
        grant_vld = 1'b1;
        grant_id  = 1'b1;
      end
    end
  end

  assign req0_ready = grant_vld & ~grant_id;
  assign req1_ready = grant_vld &  grant_id;

  assign gnt_a     = grant_id ? req1_a  : req0_a;
  assign gnt_b     = grant_id ? req1_b  : req0_b;
  assign gnt_op    = grant_id ? req1_op : req0_op;
  assign gnt_legal = {1'b0, gnt_op} < NUM_OPS_W;

  // Per-opcode flag enables {Cf,Of,Zf,Sf}; AND-masking forces disabled bits to 0 even for X inputs.
  always_comb begin
    flag_en = 4'b0010;
    case (alu_op)
      4'd0:    flag_en = 4'b1111;
      4'd1:    flag_en = 4'b0111;
      4'd2:    flag_en = 4'b1010;
      4'd6:    flag_en = 4'b1010;
      4'd11:   flag_en = 4'b1010;
      default: flag_en = 4'b0010;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_op       <= '0;
      rsp_id       <= 1'b0;
      rsp_out      <= '0;
      rsp_flags    <= '0;
      rsp_err      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_vld) begin
            last_grant_q <= grant_id;
            rsp_id       <= grant_id;
            if (gnt_legal) begin
              alu_a   <= gnt_a;
              alu_b   <= gnt_b;
              alu_op  <= gnt_op;
              state_q <= ST_EXEC;
            end else begin
              // Illegal ops bypass the ALU entirely and leave its operands untouched.
              rsp_err   <= 1'b1;
              rsp_out   <= '0;
              rsp_flags <= '0;
              state_q   <= ST_RESP;
            end
          end
        end
        ST_EXEC: begin
          rsp_out   <= alu_out;
          rsp_flags <= {alu_cf, alu_of, alu_zf, alu_sf} & flag_en;
          rsp_err   <= 1'b0;
          state_q   <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid = (state_q == ST_RESP);
  assign busy      = (state_q != ST_IDLE);

endmodule
